// File: rtl/gvp_program_sequencer.sv
// gvp_program_sequencer
//   Owns the GVP configuration bus. A start command halts the core, writes
//   reset_options, streams num_vectors records from an AXI-stream into vector
//   slots 0..n-1 (two-cycle latch/commit, bracketed by IDLE_ADDR gaps that
//   re-arm the core's setvec mode), releases reset, forwards pause while
//   running, waits for gvp_finished and puts the core back into reset.
// Ports
//   a_clk, a_resetn        clock, asynchronous active-low reset
//   start, abort           command pulses (abort wins over start)
//   num_vectors            records to load, latched on start (1..NUM_VECTORS)
//   reset_opts             reset_options value, latched on start
//   pause_req              level, forwarded to core pause bit in ARM/RUN
//   S_AXIS_VEC_*           vector record stream (one beat per vector)
//   gvp_finished           core finished flag, honoured only in RUN
//   config_addr/data       registered core configuration bus
//   busy, done             not-IDLE level / one-cycle end-of-run pulse
//   aborted, error         sticky status, cleared by an accepted start
//   state_dbg              current state encoding
module gvp_program_sequencer #(
  parameter int          NUM_VECTORS_N2 = 4,
  parameter int          NUM_VECTORS    = 16,
  parameter logic [31:0] CTRL_ADDR      = 32'd5001,
  parameter logic [31:0] RSTOPT_ADDR    = 32'd5002,
  parameter logic [31:0] VPROG_ADDR     = 32'd5003,
  parameter logic [31:0] IDLE_ADDR      = 32'd0,
  parameter int          WR_HOLD        = 3,
  parameter int          GAP_CYCLES     = 2,
  parameter int          CTRL_HOLD      = 2,
  parameter int          ARM_WAIT       = 12
) (
  input  logic                    a_clk,
  input  logic                    a_resetn,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_VECTORS_N2:0] num_vectors,
  input  logic [15:0]             reset_opts,
  input  logic                    pause_req,
  input  logic [511:0]            S_AXIS_VEC_tdata,
  input  logic                    S_AXIS_VEC_tvalid,
  output logic                    S_AXIS_VEC_tready,
  input  logic                    gvp_finished,
  output logic [31:0]             config_addr,
  output logic [511:0]            config_data,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic                    error,
  output logic [3:0]              state_dbg
);

  localparam int IW = NUM_VECTORS_N2 + 1;
  localparam int CW = 8;

  typedef enum logic [3:0] {
    S_IDLE, S_HALT, S_RSTOPT, S_GAP, S_LOAD_WAIT, S_LOAD_WR, S_ARM, S_RUN, S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d, count_q, count_d;
  logic [15:0]     opts_q, opts_d;
  logic [511:0]    rec_q, rec_d;
  logic [31:0]     addr_d;
  logic [511:0]    data_d;
  logic            tready_d, busy_d, done_d, aborted_d, error_d;
  logic            hold_done, count_ok, beat;

  // Cycles spent in a held state, minus one (counter runs down to zero).
  function automatic logic [CW-1:0] hold_len(input state_e s);
    case (s)
      S_HALT, S_RSTOPT, S_STOP: return CW'(CTRL_HOLD - 1);
      S_GAP:                    return CW'(GAP_CYCLES - 1);
      S_LOAD_WR:                return CW'(WR_HOLD - 1);
      S_ARM:                    return CW'(ARM_WAIT - 1);
      default:                  return '0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    opts_d    = opts_q;
    rec_d     = rec_q;
    aborted_d = aborted;
    error_d   = error;
    done_d    = 1'b0;
    hold_done = (cnt_q == '0);
    count_ok  = (num_vectors != '0) && (num_vectors <= IW'(NUM_VECTORS));
    beat      = S_AXIS_VEC_tvalid & S_AXIS_VEC_tready;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (count_ok) begin
            state_d   = S_HALT;
            count_d   = num_vectors;
            opts_d    = reset_opts;
            aborted_d = 1'b0;
            error_d   = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_HALT:   if (hold_done) state_d = S_RSTOPT;
      S_RSTOPT: begin
        if (hold_done) begin
          state_d = S_GAP;
          idx_d   = '0;
        end
      end
      S_GAP:    if (hold_done) state_d = (idx_q < count_q) ? S_LOAD_WAIT : S_ARM;
      S_LOAD_WAIT: begin
        if (beat) begin
          // Slot index field is owned by the sequencer, not by software.
          rec_d          = S_AXIS_VEC_tdata;
          rec_d[IW-1:0]  = idx_q;
          state_d        = S_LOAD_WR;
        end
      end
      S_LOAD_WR: begin
        if (hold_done) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_GAP;
        end
      end
      S_ARM:    if (hold_done) state_d = S_RUN;
      S_RUN:    if (gvp_finished) state_d = S_STOP;
      S_STOP: begin
        if (hold_done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default:  state_d = S_IDLE;
    endcase

    // Abort overrides everything except an already-stopping or idle core.
    // A beat handshaking in the same cycle is taken off the stream and dropped.
    if (abort && (state_q != S_IDLE) && (state_q != S_STOP)) begin
      state_d   = S_STOP;
      aborted_d = 1'b1;
    end

    // Hold counters reload whenever a new state is entered.
    if (state_d != state_q) cnt_d = hold_len(state_d);
    else                    cnt_d = hold_done ? cnt_q : cnt_q - 1'b1;

    // Bus values are derived from the next state so the registered outputs
    // line up with the registered state.
    addr_d = IDLE_ADDR;
    data_d = '0;
    case (state_d)
      S_HALT, S_STOP: begin addr_d = CTRL_ADDR;   data_d = 512'd1;           end
      S_RSTOPT:       begin addr_d = RSTOPT_ADDR; data_d = 512'(opts_d);     end
      S_LOAD_WR:      begin addr_d = VPROG_ADDR;  data_d = rec_d;            end
      S_ARM, S_RUN:   begin addr_d = CTRL_ADDR;   data_d = {510'd0, pause_req, 1'b0}; end
      default: ;
    endcase
    tready_d = (state_d == S_LOAD_WAIT);
    busy_d   = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      idx_q             <= '0;
      count_q           <= '0;
      opts_q            <= '0;
      config_addr       <= IDLE_ADDR;
      config_data       <= '0;
      S_AXIS_VEC_tready <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      aborted           <= 1'b0;
      error             <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      idx_q             <= idx_d;
      count_q           <= count_d;
      opts_q            <= opts_d;
      config_addr       <= addr_d;
      config_data       <= data_d;
      S_AXIS_VEC_tready <= tready_d;
      busy              <= busy_d;
      done              <= done_d;
      aborted           <= aborted_d;
      error             <= error_d;
    end
  end

  // NOTE: the record buffer is pure datapath; it is only observed after a
  // capture, so it carries no reset.
  always_ff @(posedge a_clk) begin
    rec_q <= rec_d;
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_gvp_program_sequencer.sv
// Self-checking bench for gvp_program_sequencer. The reference model describes
// each run as the list of bus writes the core must see (address, data, how many
// cycles) and compares it with the run-length-compressed bus activity.
module tb_gvp_program_sequencer;

  localparam int          IW        = 5;
  localparam int          WR_HOLD   = 3;
  localparam int          GAP       = 2;
  localparam int          CTRL_HOLD = 2;
  localparam int          ARM_WAIT  = 12;
  localparam logic [31:0] A_CTRL    = 32'd5001;
  localparam logic [31:0] A_RSTOPT  = 32'd5002;
  localparam logic [31:0] A_VPROG   = 32'd5003;
  localparam logic [31:0] A_IDLE    = 32'd0;

  logic          a_clk = 1'b0;
  logic          a_resetn = 1'b0;
  logic          start = 1'b0, abort = 1'b0, pause_req = 1'b0;
  logic          tvalid = 1'b0, gvp_finished = 1'b0;
  logic [IW-1:0] num_vectors = '0;
  logic [15:0]   reset_opts = '0;
  logic [511:0]  tdata = '0;
  logic          tready, busy, done, aborted, error;
  logic [31:0]   config_addr;
  logic [511:0]  config_data;
  logic [3:0]    state_dbg;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0]  addr;
    logic [511:0] data;
    int           len;
    bit           at_least;
  } seg_t;

  seg_t         exp_q[$];
  seg_t         obs_q[$];
  logic [511:0] recs[$];

  gvp_program_sequencer dut (
    .a_clk             (a_clk),
    .a_resetn          (a_resetn),
    .start             (start),
    .abort             (abort),
    .num_vectors       (num_vectors),
    .reset_opts        (reset_opts),
    .pause_req         (pause_req),
    .S_AXIS_VEC_tdata  (tdata),
    .S_AXIS_VEC_tvalid (tvalid),
    .S_AXIS_VEC_tready (tready),
    .gvp_finished      (gvp_finished),
    .config_addr       (config_addr),
    .config_data       (config_data),
    .busy              (busy),
    .done              (done),
    .aborted           (aborted),
    .error             (error),
    .state_dbg         (state_dbg)
  );

  always #5 a_clk = ~a_clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void push_exp(input logic [31:0] a, input logic [511:0] d,
                                   input int len, input bit ge);
    seg_t s;
    s.addr = a; s.data = d; s.len = len; s.at_least = ge;
    exp_q.push_back(s);
  endfunction

  // Run-length compress the bus; the pause bit of a reset-released control
  // write is checked separately, so it is folded out of the segment key.
  function automatic void record(input logic [31:0] a, input logic [511:0] d);
    logic [511:0] key;
    seg_t s;
    key = d;
    if (a == A_CTRL && d[0] == 1'b0) key[1] = 1'b0;
    if (obs_q.size() > 0 && obs_q[obs_q.size()-1].addr == a &&
        obs_q[obs_q.size()-1].data === key) begin
      s = obs_q[obs_q.size()-1];
      s.len++;
      obs_q[obs_q.size()-1] = s;
    end else begin
      s.addr = a; s.data = key; s.len = 1; s.at_least = 1'b0;
      obs_q.push_back(s);
    end
  endfunction

  // mode 0: normal run, 1: abort on first cycle of the vector-1 write,
  // 2: reset asserted while running.
  task automatic do_run(input int n, input logic [15:0] opts, input int stall_max,
                        input int first_stall, input int mode, input bit stale);
    int   ptr = 0, stall, arm_cyc = -1, fin_cyc = -1, done_cyc = -1, abort_cyc = -1;
    int   late_tready = 0, run_len, cyc;
    bit   v;
    logic pause_prev;
    recs.delete(); exp_q.delete(); obs_q.delete();
    for (int i = 0; i < n; i++) recs.push_back(rand512());
    run_len = $urandom_range(0, 20);

    push_exp(A_CTRL, 512'd1, CTRL_HOLD, 1'b0);
    push_exp(A_RSTOPT, 512'(opts), CTRL_HOLD, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (mode == 1 && i == 2) break;
      push_exp(A_IDLE, '0, GAP + 1, 1'b1);
      push_exp(A_VPROG, {recs[i][511:IW], IW'(i)}, (mode == 1 && i == 1) ? 1 : WR_HOLD, 1'b0);
    end
    if (mode != 1) begin
      push_exp(A_IDLE, '0, GAP, 1'b0);
      push_exp(A_CTRL, '0, ARM_WAIT + 1, 1'b1);
    end
    push_exp(A_CTRL, 512'd1, CTRL_HOLD, 1'b0);

    @(negedge a_clk);
    start = 1'b1; num_vectors = IW'(n); reset_opts = opts;
    pause_prev = pause_req;
    stall = first_stall;
    for (cyc = 0; cyc < 4000; cyc++) begin
      @(negedge a_clk);
      if (done) begin done_cyc = cyc; break; end
      record(config_addr, config_data);
      if (config_addr == A_CTRL && config_data[0] == 1'b0) begin
        if (arm_cyc < 0) arm_cyc = cyc;
        check("pause_follow", 512'(config_data[1]), 512'(pause_prev));
      end
      if (ptr >= n || abort_cyc >= 0) late_tready += int'(tready);
      if (mode == 2 && arm_cyc >= 0 && cyc == arm_cyc + ARM_WAIT + 4) begin
        check("pre_rst_busy", 512'(busy), 512'd1);
        #2 a_resetn = 1'b0;
        #1;
        check("rst_addr", 512'(config_addr), 512'(A_IDLE));
        check("rst_data", config_data, '0);
        check("rst_busy", 512'(busy), 512'd0);
        check("rst_tready", 512'(tready), 512'd0);
        break;
      end

      // Drive the next cycle's inputs.
      start = 1'b0; abort = 1'b0;
      num_vectors = IW'($urandom); reset_opts = 16'($urandom);
      if (mode == 1 && abort_cyc < 0 && config_addr == A_VPROG &&
          config_data[IW-1:0] == IW'(1)) begin
        abort = 1'b1; abort_cyc = cyc;
      end
      v = (ptr < n) && (stall == 0) && (abort_cyc < 0);
      if (tready && stall > 0) stall--;
      tvalid = v;
      tdata  = v ? recs[ptr] : rand512();
      if (v && tready) begin
        ptr++;
        stall = $urandom_range(0, stall_max);
      end
      pause_req  = 1'($urandom_range(0, 1));
      pause_prev = pause_req;
      gvp_finished = 1'b0;
      if (arm_cyc >= 0) begin
        if (stale && cyc < arm_cyc + 2) gvp_finished = 1'b1;
        if (mode == 0 && cyc >= arm_cyc + ARM_WAIT + run_len) begin
          gvp_finished = 1'b1;
          if (fin_cyc < 0) fin_cyc = cyc;
        end
      end
    end

    tvalid = 1'b0; gvp_finished = 1'b0; pause_req = 1'b0; abort = 1'b0; start = 1'b0;
    if (mode == 2) begin
      check("rst_reached", 512'(a_resetn), 512'd0);
      @(negedge a_clk);
      a_resetn = 1'b1;
      repeat (3) @(negedge a_clk);
      check("post_rst_addr", 512'(config_addr), 512'(A_IDLE));
      check("post_rst_busy", 512'(busy), 512'd0);
      return;
    end

    check("done_seen", 512'(done_cyc >= 0), 512'd1);
    check("done_addr", 512'(config_addr), 512'(A_IDLE));
    check("done_busy", 512'(busy), 512'd0);
    check("seg_count", 512'(obs_q.size()), 512'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("seg%0d_addr", i), 512'(obs_q[i].addr), 512'(exp_q[i].addr));
      check($sformatf("seg%0d_data", i), obs_q[i].data, exp_q[i].data);
      if (exp_q[i].at_least)
        check($sformatf("seg%0d_minlen", i), 512'(obs_q[i].len >= exp_q[i].len), 512'd1);
      else
        check($sformatf("seg%0d_len", i), 512'(obs_q[i].len), 512'(exp_q[i].len));
    end
    check("beats", 512'(ptr), 512'((mode == 1) ? 2 : n));
    check("late_tready", 512'(late_tready), 512'd0);
    check("aborted", 512'(aborted), 512'(mode == 1));
    check("error_clear", 512'(error), 512'd0);
    if (mode == 0) check("fin_to_done", 512'(done_cyc - fin_cyc), 512'(CTRL_HOLD + 1));
    else           check("abort_to_done", 512'(done_cyc - abort_cyc), 512'(CTRL_HOLD + 1));
    @(negedge a_clk);
    check("done_pulse", 512'(done), 512'd0);
  endtask

  // Rejected start: error set, core bus never touched.
  task automatic bad_start(input int n);
    int stray = 0;
    @(negedge a_clk);
    start = 1'b1; num_vectors = IW'(n);
    @(negedge a_clk);
    start = 1'b0;
    check($sformatf("err_flag_%0d", n), 512'(error), 512'd1);
    for (int i = 0; i < 5; i++) begin
      stray += int'(busy) + int'(config_addr != A_IDLE);
      @(negedge a_clk);
    end
    check($sformatf("err_quiet_%0d", n), 512'(stray), 512'd0);
  endtask

  initial begin
    #3;
    check("rst_addr0", 512'(config_addr), 512'(A_IDLE));
    check("rst_data0", config_data, '0);
    check("rst_flags0", 512'({tready, busy, done, aborted, error}), 512'd0);
    @(negedge a_clk);
    a_resetn = 1'b1;

    bad_start(0);
    bad_start(17);

    // Abort in the same cycle as a valid start: start is ignored.
    @(negedge a_clk);
    start = 1'b1; abort = 1'b1; num_vectors = IW'(4);
    @(negedge a_clk);
    start = 1'b0; abort = 1'b0;
    @(negedge a_clk);
    check("abort_beats_start", 512'(busy), 512'd0);
    check("error_kept", 512'(error), 512'd1);

    do_run(2, 16'h00A5, 0, 0, 0, 1'b0);
    do_run(3, 16'($urandom), 2, 50, 0, 1'b1);
    do_run(3, 16'($urandom), 1, 0, 1, 1'b0);
    for (int r = 0; r < 6; r++)
      do_run($urandom_range(1, 16), 16'($urandom), 3, 0, 0, 1'($urandom_range(0, 1)));
    do_run(4, 16'($urandom), 1, 0, 2, 1'b1);
    do_run(16, 16'($urandom), 2, 0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
